// File: rtl/rf_rpt_pkg.sv
// Shared constants for the RF report concentrator: host command words, reply/diag headers,
// default frequency word and the source-id width helper.
package rf_rpt_pkg;

    localparam logic [15:0] CMD_FREQ_HDR = 16'hCBBC;
    localparam logic [63:0] CMD_QUERY    = 64'hBBBB_111A_A222_0000;
    localparam logic [63:0] CMD_CLR_OVF  = 64'hBBBB_111A_A222_00FF;
    localparam logic [31:0] REPLY_HDR    = 32'hBBBB_BBBB;
    localparam logic [15:0] DIAG_HDR     = 16'hEEEE;
    localparam logic [43:0] FREQ_DEFAULT = 44'h08432E147AE;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int ch_width(input int num_ch);
        return $clog2(num_ch + 2);
    endfunction

    function automatic logic [63:0] diag_word(input logic [7:0] ch, input logic [31:0] cnt);
        return {DIAG_HDR, ch, 8'd0, cnt};
    endfunction

endpackage

// File: rtl/rpt_fifo.sv
// Per-channel synchronous report FIFO; a push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module rpt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk_20mhz,
    input  logic             sys_rest,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             full_s;
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags and accepted push/pop
    always_comb begin
        empty   = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_en_s = pop && !empty;
        wr_en_s = push && (!full_s || rd_en_s);
        drop    = push && full_s && !rd_en_s;
        dout    = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Read/write pointers
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, contents are don't-care while empty
    always_ff @(posedge clk_20mhz) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rf_report_arbiter.sv
// RF control-plane report concentrator: per-channel FIFOs, round-robin report port, host command
// decode and 1 s poll tick. Define RPT_OVF_REPORT_EN to add the overflow diagnostic report slot.
module rf_report_arbiter
    import rf_rpt_pkg::*;
#(
    parameter  int NUM_CH   = 8,
    parameter  int DEPTH    = 4,
    parameter  int TICK_CNT = 20000000,
    localparam int CH_W     = ch_width(NUM_CH)
) (
    input  logic                  clk_20mhz,
    input  logic                  sys_rest,
    input  logic [NUM_CH-1:0]     rpt_vld,
    input  logic [NUM_CH*64-1:0]  rpt_data,
    input  logic                  rv_uart_vld,
    input  logic [63:0]           rv_uart_data,
    input  logic [35:0]           rf_freq_data,
    input  logic [1:0]            sig_mode,
    input  logic                  send_rdy,
    output logic                  send_en,
    output logic [63:0]           send_data,
    output logic [CH_W-1:0]       send_ch,
    output logic                  tick_1s,
    output logic [43:0]           freq_rf_ctr,
    output logic                  freq_rf_ctr_stat,
    output logic [35:0]           freq_rf_ctr_slc,
    output logic [NUM_CH-1:0]     ovf_flag
);
    localparam int NREQ = NUM_CH + 2;
    localparam logic [31:0] TICK_LAST = 32'(TICK_CNT);

    logic [NUM_CH-1:0] fifo_empty_s;
    logic [NUM_CH-1:0] fifo_drop_s;
    logic [NUM_CH-1:0] fifo_pop_s;
    logic [63:0]       fifo_dout_s [NUM_CH];
    logic [NREQ-1:0]   req_s;
    logic [63:0]       req_data_s [NREQ];

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic [CH_W-1:0]   last_grant_r;
    logic [CH_W-1:0]   grant_id_s;
    logic [CH_W-1:0]   rr_idx_s;
    logic [63:0]       grant_data_s;
    logic              grant_s;
    logic              load_s;
    logic              release_s;

    logic              local_vld_r;
    logic [63:0]       local_data_r;
    logic              local_pop_s;
    logic              diag_vld_s;
    logic [63:0]       diag_data_s;

    logic              cmd_freq_s;
    logic              cmd_query_s;
    logic              cmd_clr_s;
    logic              freq_flag_r;
    logic [31:0]       tick_cnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rpt_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
            .clk_20mhz (clk_20mhz),
            .sys_rest  (sys_rest),
            .push      (rpt_vld[g]),
            .din       (rpt_data[g*64 +: 64]),
            .pop       (fifo_pop_s[g]),
            .dout      (fifo_dout_s[g]),
            .empty     (fifo_empty_s[g]),
            .drop      (fifo_drop_s[g])
        );
    end

    // Poll tick: counter wraps at TICK_LAST, tick follows the wrap by one cycle
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            tick_cnt_r <= 32'd0;
            tick_1s    <= 1'b1;
        end else if (tick_cnt_r == TICK_LAST) begin
            tick_cnt_r <= 32'd0;
            tick_1s    <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + 32'd1;
            tick_1s    <= 1'b0;
        end
    end

    // Host command decode
    always_comb begin
        cmd_freq_s  = rv_uart_vld && (rv_uart_data[63:48] == CMD_FREQ_HDR);
        cmd_query_s = rv_uart_vld && (rv_uart_data == CMD_QUERY);
        cmd_clr_s   = rv_uart_vld && (rv_uart_data == CMD_CLR_OVF);
        freq_rf_ctr_slc = freq_flag_r ? freq_rf_ctr[35:0] : rf_freq_data;
    end

    // Latched host frequency word and its one-cycle update strobe
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            freq_rf_ctr      <= FREQ_DEFAULT;
            freq_flag_r      <= 1'b0;
            freq_rf_ctr_stat <= 1'b0;
        end else begin
            freq_rf_ctr_stat <= cmd_freq_s;
            if (cmd_freq_s) begin
                freq_rf_ctr <= rv_uart_data[43:0];
                freq_flag_r <= rv_uart_data[44];
            end
        end
    end

    // Local reply slot; a fresh query overwrites an unsent reply
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            local_vld_r  <= 1'b0;
            local_data_r <= 64'd0;
        end else if (cmd_query_s) begin
            local_vld_r  <= 1'b1;
            local_data_r <= {REPLY_HDR, 30'd0, sig_mode};
        end else if (local_pop_s) begin
            local_vld_r  <= 1'b0;
        end
    end

    // Sticky drop flags; the clear command beats a same-cycle drop
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            ovf_flag <= {NUM_CH{1'b0}};
        end else if (cmd_clr_s) begin
            ovf_flag <= {NUM_CH{1'b0}};
        end else begin
            ovf_flag <= ovf_flag | fifo_drop_s;
        end
    end

`ifdef RPT_OVF_REPORT_EN
    logic [31:0] drop_cnt_r;
    logic [31:0] drop_cnt_next_s;
    logic [32:0] drop_sum_s;
    logic [7:0]  drop_ch_s;
    logic        diag_vld_r;
    logic [63:0] diag_data_r;
    logic        diag_pop_s;

    // Saturating drop count and lowest dropping channel for the diag word
    always_comb begin
        drop_ch_s  = 8'd0;
        drop_sum_s = {1'b0, drop_cnt_r};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fifo_drop_s[i]) begin
                drop_ch_s  = 8'(i);
                drop_sum_s = drop_sum_s + 33'd1;
            end else begin
                drop_sum_s = drop_sum_s;
            end
        end
        drop_cnt_next_s = drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
        diag_pop_s      = load_s && (grant_id_s == CH_W'(NUM_CH + 1));
        diag_vld_s      = diag_vld_r;
        diag_data_s     = diag_data_r;
    end

    // Drop counter and diagnostic slot
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            drop_cnt_r  <= 32'd0;
            diag_vld_r  <= 1'b0;
            diag_data_r <= 64'd0;
        end else begin
            drop_cnt_r <= cmd_clr_s ? 32'd0 : drop_cnt_next_s;
            if (|fifo_drop_s && !diag_vld_r) begin
                diag_vld_r  <= 1'b1;
                diag_data_r <= diag_word(drop_ch_s, drop_cnt_next_s);
            end else if (diag_pop_s) begin
                diag_vld_r  <= 1'b0;
            end
        end
    end
`else
    // Diagnostic slot absent: never requests
    always_comb begin
        diag_vld_s  = 1'b0;
        diag_data_s = 64'd0;
    end
`endif

    // Requester vector and round-robin search starting after the last grant
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_s[i]      = !fifo_empty_s[i];
            req_data_s[i] = fifo_dout_s[i];
        end
        req_s[NUM_CH]        = local_vld_r;
        req_data_s[NUM_CH]   = local_data_r;
        req_s[NUM_CH+1]      = diag_vld_s;
        req_data_s[NUM_CH+1] = diag_data_s;

        grant_s      = 1'b0;
        grant_id_s   = {CH_W{1'b0}};
        grant_data_s = 64'd0;
        rr_idx_s     = {CH_W{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx_s = CH_W'((int'(last_grant_r) + k) % NREQ);
            if (!grant_s && req_s[rr_idx_s]) begin
                grant_s      = 1'b1;
                grant_id_s   = rr_idx_s;
                grant_data_s = req_data_s[rr_idx_s];
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Arbiter next state and per-requester pop strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (grant_s) begin
                    load_s       = 1'b1;
                    next_state_s = ARB_HOLD;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_HOLD: begin
                if (send_rdy) begin
                    release_s    = 1'b1;
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_HOLD;
                end
            end
            default: next_state_s = ARB_IDLE;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_pop_s[i] = load_s && (grant_id_s == CH_W'(i));
        end
        local_pop_s = load_s && (grant_id_s == CH_W'(NUM_CH));
    end

    // Arbiter state register
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered report port; word and id are held until accepted
    always_ff @(posedge clk_20mhz or posedge sys_rest) begin
        if (sys_rest) begin
            send_en      <= 1'b0;
            send_data    <= 64'd0;
            send_ch      <= {CH_W{1'b0}};
            last_grant_r <= CH_W'(NUM_CH + 1);
        end else if (load_s) begin
            send_en      <= 1'b1;
            send_data    <= grant_data_s;
            send_ch      <= grant_id_s;
            last_grant_r <= grant_id_s;
        end else if (release_s) begin
            send_en      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_report_arbiter.sv
// Directed bench for rf_report_arbiter: vector table for single transactions plus sequences for
// tick period, burst arbitration, overflow and asynchronous reset.
module tb_rf_report_arbiter;
    localparam int NUM_CH = 8;
    localparam int CH_W   = 4;
    localparam int K_PUSH = 0;
    localparam int K_QRY  = 1;
    localparam int K_FREQ = 2;
    localparam logic [35:0] RF_IN = 36'h9_8765_4321;

    logic                 clk_20mhz = 1'b0;
    logic                 sys_rest;
    logic [NUM_CH-1:0]    rpt_vld;
    logic [NUM_CH*64-1:0] rpt_data;
    logic                 rv_uart_vld;
    logic [63:0]          rv_uart_data;
    logic [35:0]          rf_freq_data;
    logic [1:0]           sig_mode;
    logic                 send_rdy;
    logic                 send_en;
    logic [63:0]          send_data;
    logic [CH_W-1:0]      send_ch;
    logic                 tick_1s;
    logic [43:0]          freq_rf_ctr;
    logic                 freq_rf_ctr_stat;
    logic [35:0]          freq_rf_ctr_slc;
    logic [NUM_CH-1:0]    ovf_flag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          kind;
        int          ch;
        logic [63:0] data;
        logic [1:0]  mode;
        logic [63:0] exp_data;
        int          exp_ch;
        logic [43:0] exp_freq;
        logic [35:0] exp_slc;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] got_d [$];
    int          got_c [$];
    logic [63:0] exp_d [$];
    int          exp_c [$];

    rf_report_arbiter #(.NUM_CH(NUM_CH), .DEPTH(4), .TICK_CNT(9)) dut (
        .clk_20mhz        (clk_20mhz),
        .sys_rest         (sys_rest),
        .rpt_vld          (rpt_vld),
        .rpt_data         (rpt_data),
        .rv_uart_vld      (rv_uart_vld),
        .rv_uart_data     (rv_uart_data),
        .rf_freq_data     (rf_freq_data),
        .sig_mode         (sig_mode),
        .send_rdy         (send_rdy),
        .send_en          (send_en),
        .send_data        (send_data),
        .send_ch          (send_ch),
        .tick_1s          (tick_1s),
        .freq_rf_ctr      (freq_rf_ctr),
        .freq_rf_ctr_stat (freq_rf_ctr_stat),
        .freq_rf_ctr_slc  (freq_rf_ctr_slc),
        .ovf_flag         (ovf_flag)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk_20mhz);
    endtask

    // Accept every offered word for ncyc cycles, recording data and source id
    task automatic collect(input int ncyc);
        send_rdy = 1'b1;
        got_d.delete();
        got_c.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (send_en) begin
                got_d.push_back(send_data);
                got_c.push_back(int'(send_ch));
            end
            nxt();
        end
    endtask

    task automatic compare_lists(input string name);
        chk({name, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                chk($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
                chk($sformatf("%s_ch%0d", name, i), 64'(got_c[i]), 64'(exp_c[i]));
            end
        end
        exp_d.delete();
        exp_c.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{K_PUSH, 2, 64'h1122_3344_5566_7788, 2'b00, 64'h1122_3344_5566_7788, 2, 44'd0, 36'd0};
        vecs[1] = '{K_PUSH, 0, 64'hDEAD_BEEF_0000_0001, 2'b00, 64'hDEAD_BEEF_0000_0001, 0, 44'd0, 36'd0};
        vecs[2] = '{K_PUSH, 7, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 7, 44'd0, 36'd0};
        vecs[3] = '{K_QRY,  0, 64'hBBBB_111A_A222_0000, 2'b10, 64'hBBBB_BBBB_0000_0002, 8, 44'd0, 36'd0};
        vecs[4] = '{K_FREQ, 0, 64'hCBBC_1000_0000_1234, 2'b00, 64'd0, 0, 44'h00000001234, 36'h000001234};
        vecs[5] = '{K_FREQ, 0, 64'hCBBC_0FFF_FFFF_FFFF, 2'b00, 64'd0, 0, 44'hFFFFFFFFFFF, RF_IN};
        vecs[6] = '{K_QRY,  0, 64'hBBBB_111A_A222_0000, 2'b01, 64'hBBBB_BBBB_0000_0001, 8, 44'd0, 36'd0};

        sys_rest     = 1'b1;
        rpt_vld      = '0;
        rpt_data     = '0;
        rv_uart_vld  = 1'b0;
        rv_uart_data = 64'd0;
        rf_freq_data = RF_IN;
        sig_mode     = 2'b00;
        send_rdy     = 1'b1;
        repeat (3) nxt();
        sys_rest = 1'b0;

        // Reset values and tick period of TICK_CNT+1 = 10
        for (int k = 0; k < 30; k++) begin
            if (k == 0) begin
                chk("rst_send_en", 64'(send_en), 64'd0);
                chk("rst_send_data", send_data, 64'd0);
                chk("rst_send_ch", 64'(send_ch), 64'd0);
                chk("rst_freq", 64'(freq_rf_ctr), 64'h0000_0843_2E14_7AE);
                chk("rst_stat", 64'(freq_rf_ctr_stat), 64'd0);
                chk("rst_slc", 64'(freq_rf_ctr_slc), 64'(RF_IN));
                chk("rst_ovf", 64'(ovf_flag), 64'd0);
            end
            chk($sformatf("tick_k%0d", k), 64'(tick_1s), 64'((k % 10) == 0));
            nxt();
        end

        // Single transactions from the vector table
        for (int v = 0; v < 7; v++) begin
            send_rdy = 1'b1;
            if (vecs[v].kind == K_PUSH) begin
                rpt_vld[vecs[v].ch] = 1'b1;
                rpt_data[vecs[v].ch*64 +: 64] = vecs[v].data;
            end else begin
                rv_uart_vld  = 1'b1;
                rv_uart_data = vecs[v].data;
                sig_mode     = vecs[v].mode;
            end
            nxt();
            rpt_vld     = '0;
            rv_uart_vld = 1'b0;
            if (vecs[v].kind == K_FREQ) begin
                chk($sformatf("v%0d_freq", v), 64'(freq_rf_ctr), 64'(vecs[v].exp_freq));
                chk($sformatf("v%0d_stat_hi", v), 64'(freq_rf_ctr_stat), 64'd1);
                chk($sformatf("v%0d_slc", v), 64'(freq_rf_ctr_slc), 64'(vecs[v].exp_slc));
                nxt();
                chk($sformatf("v%0d_stat_lo", v), 64'(freq_rf_ctr_stat), 64'd0);
            end else begin
                chk($sformatf("v%0d_en_early", v), 64'(send_en), 64'd0);
                nxt();
                chk($sformatf("v%0d_en", v), 64'(send_en), 64'd1);
                chk($sformatf("v%0d_data", v), send_data, vecs[v].exp_data);
                chk($sformatf("v%0d_ch", v), 64'(send_ch), 64'(vecs[v].exp_ch));
                nxt();
                chk($sformatf("v%0d_en_drop", v), 64'(send_en), 64'd0);
            end
        end

        // All channels push together: served ch0..ch7 in order, nothing dropped
        for (int i = 0; i < NUM_CH; i++) begin
            rpt_vld[i] = 1'b1;
            rpt_data[i*64 +: 64] = 64'hA0A0_0000_0000_0000 + 64'(i);
            exp_d.push_back(64'hA0A0_0000_0000_0000 + 64'(i));
            exp_c.push_back(i);
        end
        nxt();
        rpt_vld = '0;
        collect(20);
        compare_lists("burst");
        chk("burst_ovf", 64'(ovf_flag), 64'd0);

        // Overflow: hold the port with a ch3 word, then ch0 pushes 6 words into DEPTH 4
        send_rdy = 1'b0;
        rpt_vld[3] = 1'b1;
        rpt_data[3*64 +: 64] = 64'h3333_0000_0000_00B0;
        nxt();
        rpt_vld = '0;
        nxt();
        chk("ovf_blocker_en", 64'(send_en), 64'd1);
        for (int w = 1; w <= 6; w++) begin
            rpt_vld[0] = 1'b1;
            rpt_data[63:0] = 64'h0C00_0000_0000_0000 + 64'(w);
            nxt();
        end
        rpt_vld = '0;
        chk("ovf_flag_set", 64'(ovf_flag), 64'h01);
        chk("ovf_blocker_held", send_data, 64'h3333_0000_0000_00B0);
        exp_d.push_back(64'h3333_0000_0000_00B0);
        exp_c.push_back(3);
`ifdef RPT_OVF_REPORT_EN
        exp_d.push_back(64'hEEEE_0000_0000_0001);
        exp_c.push_back(NUM_CH + 1);
`endif
        for (int w = 1; w <= 4; w++) begin
            exp_d.push_back(64'h0C00_0000_0000_0000 + 64'(w));
            exp_c.push_back(0);
        end
        collect(24);
        compare_lists("ovf");

        // Clear command drops the sticky flags
        rv_uart_vld  = 1'b1;
        rv_uart_data = 64'hBBBB_111A_A222_00FF;
        nxt();
        rv_uart_vld = 1'b0;
        chk("ovf_cleared", 64'(ovf_flag), 64'd0);

        // Reset while holding a word: outputs fall at once, queued words lost, freq default
        send_rdy   = 1'b0;
        rpt_vld[5] = 1'b1;
        rpt_vld[1] = 1'b1;
        rpt_data[5*64 +: 64] = 64'h5555_0000_0000_0005;
        rpt_data[1*64 +: 64] = 64'h1111_0000_0000_0001;
        nxt();
        rpt_vld = '0;
        nxt();
        chk("hold_en", 64'(send_en), 64'd1);
        #5;
        sys_rest = 1'b1;
        #1;
        chk("arst_send_en", 64'(send_en), 64'd0);
        chk("arst_send_data", send_data, 64'd0);
        chk("arst_freq", 64'(freq_rf_ctr), 64'h0000_0843_2E14_7AE);
        chk("arst_tick", 64'(tick_1s), 64'd1);
        nxt();
        sys_rest = 1'b0;
        collect(10);
        compare_lists("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
